// File: rtl/vcve2_vec_elem_seq.sv
// Vector element sequencer: steps one 32-bit VRF word at a time through the EX block
// (read vs1/vs2/vs3, hold operands until ex_valid, write vd with tail byte masking).
module vcve2_vec_elem_seq #(
  parameter int VLEN = 128,
  localparam int WPR = VLEN / 32,
  localparam int VLW = $clog2(VLEN / 8) + 1,
  localparam int AW  = $clog2(32 * WPR)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  input  logic [VLW-1:0] vl_i,
  input  logic [2:0]    vsew_i,
  input  logic [4:0]    vs1_i,
  input  logic [4:0]    vs2_i,
  input  logic [4:0]    vs3_i,
  input  logic [4:0]    vd_i,
  input  logic          scalar_sel_i,
  input  logic [31:0]   scalar_i,
  input  logic          flush_i,
  output logic          vrf_re_o,
  output logic [AW-1:0] vrf_raddr_a_o,
  output logic [AW-1:0] vrf_raddr_b_o,
  output logic [AW-1:0] vrf_raddr_c_o,
  input  logic [31:0]   vrf_rdata_a_i,
  input  logic [31:0]   vrf_rdata_b_i,
  input  logic [31:0]   vrf_rdata_c_i,
  output logic [31:0]   ex_operand_a_o,
  output logic [31:0]   ex_operand_b_o,
  output logic [31:0]   ex_operand_c_o,
  output logic          ex_first_cycle_o,
  input  logic          ex_valid_i,
  input  logic [31:0]   ex_result_i,
  output logic          vrf_we_o,
  output logic [AW-1:0] vrf_waddr_o,
  output logic [31:0]   vrf_wdata_o,
  output logic [3:0]    vrf_wbe_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int NBW = VLW + 2;
  localparam int WIW = (WPR > 1) ? $clog2(WPR) : 1;

  localparam logic [2:0] VSEW_8  = 3'b000;
  localparam logic [2:0] VSEW_16 = 3'b001;
  localparam logic [2:0] VSEW_32 = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_FIN
  } state_e;

  state_e           r_state;
  state_e           w_next;

  logic [4:0]       r_vs1, r_vs2, r_vs3, r_vd;
  logic [NBW-1:0]   r_nbytes;
  logic             r_scalar_sel;
  logic [31:0]      r_scalar_rep;
  logic             r_illegal;
  logic [WIW-1:0]   r_widx;
  logic             r_first;
  logic [31:0]      r_op_a, r_op_b, r_op_c;
  logic [31:0]      r_result;

  logic             w_accept;
  logic             w_legal;
  logic [1:0]       w_shift;
  logic [NBW-1:0]   w_nbytes;
  logic [NBW-1:0]   w_nwords;
  logic             w_last;
  logic [31:0]      w_src_a;

  function automatic logic [31:0] replicate_scalar(input logic [2:0] sew, input logic [31:0] s);
    case (sew)
      VSEW_8:  replicate_scalar = {4{s[7:0]}};
      VSEW_16: replicate_scalar = {2{s[15:0]}};
      default: replicate_scalar = s;
    endcase
  endfunction

  // Only the final word of an op can be partial; rem==0 means it is full.
  function automatic logic [3:0] tail_be(input logic [1:0] rem);
    case (rem)
      2'd1:    tail_be = 4'b0001;
      2'd2:    tail_be = 4'b0011;
      2'd3:    tail_be = 4'b0111;
      default: tail_be = 4'b1111;
    endcase
  endfunction

  always_comb begin
    w_legal = 1'b1;
    w_shift = 2'd0;
    case (vsew_i)
      VSEW_8:  w_shift = 2'd0;
      VSEW_16: w_shift = 2'd1;
      VSEW_32: w_shift = 2'd2;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_nbytes = NBW'(vl_i) << w_shift;
  assign w_nwords = (r_nbytes + NBW'(3)) >> 2;
  assign w_last   = (NBW'(r_widx) + NBW'(1)) >= w_nwords;
  assign w_src_a  = r_scalar_sel ? r_scalar_rep : vrf_rdata_a_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    instr_ready_o    = (r_state == S_IDLE);
    vrf_re_o         = 1'b0;
    vrf_we_o         = 1'b0;
    done_o           = 1'b0;
    err_o            = 1'b0;
    ex_first_cycle_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid_i) begin
          w_accept = !flush_i;
          w_next   = (vl_i != '0 && w_legal) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        vrf_re_o = 1'b1;
        w_next   = S_EXEC;
      end
      S_EXEC: begin
        ex_first_cycle_o = r_first;
        if (ex_valid_i) w_next = S_WB;
      end
      S_WB: begin
        vrf_we_o = !flush_i;
        w_next   = w_last ? S_FIN : S_READ;
      end
      S_FIN: begin
        done_o = !flush_i;
        err_o  = !flush_i && r_illegal;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A kill wins over every transition, including the write in WB.
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vs1        <= '0;
      r_vs2        <= '0;
      r_vs3        <= '0;
      r_vd         <= '0;
      r_nbytes     <= '0;
      r_scalar_sel <= 1'b0;
      r_scalar_rep <= '0;
      r_illegal    <= 1'b0;
      r_widx       <= '0;
      r_first      <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_c       <= '0;
      r_result     <= '0;
    end else begin
      if (w_accept) begin
        r_vs1        <= vs1_i;
        r_vs2        <= vs2_i;
        r_vs3        <= vs3_i;
        r_vd         <= vd_i;
        r_nbytes     <= w_nbytes;
        r_scalar_sel <= scalar_sel_i;
        r_scalar_rep <= replicate_scalar(vsew_i, scalar_i);
        r_illegal    <= !w_legal;
        r_widx       <= '0;
      end
      case (r_state)
        S_READ: r_first <= 1'b1;
        S_EXEC: begin
          // Read data is only guaranteed on the first EXEC cycle, so hold a copy.
          if (r_first) begin
            r_op_a  <= w_src_a;
            r_op_b  <= vrf_rdata_b_i;
            r_op_c  <= vrf_rdata_c_i;
            r_first <= 1'b0;
          end
          if (ex_valid_i) r_result <= ex_result_i;
        end
        S_WB: if (!flush_i && !w_last) r_widx <= r_widx + 1'b1;
        default: ;
      endcase
    end
  end

  assign ex_operand_a_o = (r_state == S_EXEC && r_first) ? w_src_a       : r_op_a;
  assign ex_operand_b_o = (r_state == S_EXEC && r_first) ? vrf_rdata_b_i : r_op_b;
  assign ex_operand_c_o = (r_state == S_EXEC && r_first) ? vrf_rdata_c_i : r_op_c;

  assign vrf_raddr_a_o = AW'(r_vs1) * AW'(WPR) + AW'(r_widx);
  assign vrf_raddr_b_o = AW'(r_vs2) * AW'(WPR) + AW'(r_widx);
  assign vrf_raddr_c_o = AW'(r_vs3) * AW'(WPR) + AW'(r_widx);
  assign vrf_waddr_o   = AW'(r_vd)  * AW'(WPR) + AW'(r_widx);
  assign vrf_wdata_o   = r_result;
  assign vrf_wbe_o     = w_last ? tail_be(r_nbytes[1:0]) : 4'hF;

endmodule

// File: tb/tb_vcve2_vec_elem_seq.sv
// Bench for vcve2_vec_elem_seq: VRF and EX models around the DUT, expected VRF writes
// queued at issue time and compared as the DUT writes them.
module tb_vcve2_vec_elem_seq;

  localparam int VLEN = 128;
  localparam int WPR  = VLEN / 32;
  localparam int VLW  = $clog2(VLEN / 8) + 1;
  localparam int AW   = $clog2(32 * WPR);

  logic          clk, rst_n;
  logic          instr_valid, instr_ready;
  logic [VLW-1:0] vl;
  logic [2:0]    vsew;
  logic [4:0]    vs1, vs2, vs3, vd;
  logic          scalar_sel;
  logic [31:0]   scalar;
  logic          flush;
  logic          vrf_re;
  logic [AW-1:0] raddr_a, raddr_b, raddr_c;
  logic [31:0]   rdata_a, rdata_b, rdata_c;
  logic [31:0]   op_a, op_b, op_c;
  logic          ex_first;
  logic          ex_valid;
  logic [31:0]   ex_result;
  logic          vrf_we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [3:0]    wbe;
  logic          done, err;

  vcve2_vec_elem_seq #(.VLEN(VLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .vl_i(vl), .vsew_i(vsew),
    .vs1_i(vs1), .vs2_i(vs2), .vs3_i(vs3), .vd_i(vd),
    .scalar_sel_i(scalar_sel), .scalar_i(scalar), .flush_i(flush),
    .vrf_re_o(vrf_re),
    .vrf_raddr_a_o(raddr_a), .vrf_raddr_b_o(raddr_b), .vrf_raddr_c_o(raddr_c),
    .vrf_rdata_a_i(rdata_a), .vrf_rdata_b_i(rdata_b), .vrf_rdata_c_i(rdata_c),
    .ex_operand_a_o(op_a), .ex_operand_b_o(op_b), .ex_operand_c_o(op_c),
    .ex_first_cycle_o(ex_first), .ex_valid_i(ex_valid), .ex_result_i(ex_result),
    .vrf_we_o(vrf_we), .vrf_waddr_o(waddr), .vrf_wdata_o(wdata), .vrf_wbe_o(wbe),
    .done_o(done), .err_o(err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:32*WPR-1];
  int checks = 0, errors = 0;
  int cyc = 0;
  int wr_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0;
  int done_cyc = 0, done_start = 0, acc = 0;
  logic err_at_done = 1'b0;
  int ex_wait = 0, ex_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read VRF: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (vrf_re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
      rdata_c <= mem[raddr_c];
    end
  end

  // EX model: result = a + (b ^ c), valid after ex_wait stalled cycles.
  always @(posedge clk) ex_cnt <= ex_first ? 1 : ex_cnt + 1;
  assign ex_valid  = ex_first ? (ex_wait == 0) : (ex_cnt >= ex_wait);
  assign ex_result = op_a + (op_b ^ op_c);

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (vrf_we) begin
        wr_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h be=%b, required no write", waddr, wdata, wbe);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({waddr, wdata, wbe} !== {e.addr, e.data, e.be}) begin
            errors++;
            $display("FAIL vrf_write: got addr=%0d data=%h be=%b, required addr=%0d data=%h be=%b",
                     waddr, wdata, wbe, e.addr, e.data, e.be);
          end
        end
      end
      if (vrf_re) re_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        err_at_done = err;
      end
      if (err) err_cnt++;
    end
  end

  task automatic issue(input int vl_v, input logic [2:0] sew, input int s1, input int s2,
                       input int s3, input int d, input logic ssel, input logic [31:0] sc,
                       input int npush);
    int bpe, nbytes, nw, rem;
    logic [31:0] a, rep;
    exp_t e;
    @(negedge clk);
    vl = VLW'(vl_v); vsew = sew; vs1 = 5'(s1); vs2 = 5'(s2); vs3 = 5'(s3); vd = 5'(d);
    scalar_sel = ssel; scalar = sc;
    instr_valid = 1'b1;
    acc = cyc;
    done_start = done_cnt;
    if (sew == 3'b000) begin bpe = 1; rep = {24'h0, sc[7:0]} * 32'h0101_0101; end
    else if (sew == 3'b001) begin bpe = 2; rep = {16'h0, sc[15:0]} * 32'h0001_0001; end
    else if (sew == 3'b010) begin bpe = 4; rep = sc; end
    else begin bpe = 0; rep = sc; end
    nbytes = vl_v * bpe;
    nw = (nbytes + 3) / 4;
    rem = nbytes % 4;
    for (int w = 0; w < nw; w++) begin
      if (npush >= 0 && w >= npush) break;
      a = ssel ? rep : mem[s1 * WPR + w];
      e.addr = AW'(d * WPR + w);
      e.data = a + (mem[s2 * WPR + w] ^ mem[s3 * WPR + w]);
      e.be   = (w == nw - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
      sb.push_back(e);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt != done_start) break;
      @(negedge clk);
    end
    lat = (done_cnt != done_start) ? done_cyc - acc : -1;
  endtask

  task automatic test_reset();
    checks++;
    if ({instr_ready, vrf_re, vrf_we, done, err, ex_first} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/re/we/done/err/first=%b, required 100000",
               {instr_ready, vrf_re, vrf_we, done, err, ex_first});
    end
    checks++;
    if ({op_a, op_b, op_c} !== 96'h0) begin
      errors++;
      $display("FAIL reset_operands: got %h %h %h, required zero", op_a, op_b, op_c);
    end
  endtask

  task automatic test_sew32_full();
    int lat, w0;
    w0 = wr_cnt;
    issue(4, 3'b010, 1, 2, 3, 5, 1'b0, 32'h0, -1);
    wait_done(lat);
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL sew32_latency: got %0d, required 13", lat); end
    checks++;
    if (wr_cnt - w0 !== 4 || sb.size() != 0) begin
      errors++; $display("FAIL sew32_writes: got %0d writes (%0d pending), required 4", wr_cnt - w0, sb.size());
    end
    checks++;
    if (err_at_done !== 1'b0) begin errors++; $display("FAIL sew32_err: got %b, required 0", err_at_done); end
  endtask

  task automatic test_sew8_tail();
    int lat, w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    issue(5, 3'b000, 6, 7, 8, 9, 1'b0, 32'h0, -1);
    wait_done(lat);
    repeat (4) @(negedge clk);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL sew8_latency: got %0d, required 7", lat); end
    checks++;
    if (wr_cnt - w0 !== 2 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL sew8_counts: got %0d writes %0d dones, required 2 writes 1 done", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_vl_zero();
    int lat, w0, r0;
    w0 = wr_cnt;
    r0 = re_cnt;
    issue(0, 3'b010, 1, 2, 3, 4, 1'b0, 32'h0, -1);
    wait_done(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL vl0_latency: got %0d, required 1", lat); end
    checks++;
    if (wr_cnt != w0 || re_cnt != r0 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL vl0_activity: got writes=%0d reads=%0d err=%b, required 0 0 0", wr_cnt - w0, re_cnt - r0, err_at_done);
    end
  endtask

  task automatic test_ex_stall();
    int lat;
    logic [31:0] ha, hb, hc;
    ex_wait = 3;
    issue(2, 3'b010, 10, 11, 12, 13, 1'b0, 32'h0, -1);
    @(negedge clk);
    checks++;
    if (ex_first !== 1'b1 || op_a !== mem[10 * WPR] || op_b !== mem[11 * WPR] || op_c !== mem[12 * WPR]) begin
      errors++;
      $display("FAIL stall_first: got first=%b a=%h b=%h c=%h, required 1 %h %h %h",
               ex_first, op_a, op_b, op_c, mem[10 * WPR], mem[11 * WPR], mem[12 * WPR]);
    end
    ha = mem[10 * WPR]; hb = mem[11 * WPR]; hc = mem[12 * WPR];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ex_first !== 1'b0 || {op_a, op_b, op_c} !== {ha, hb, hc}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got first=%b a=%h b=%h c=%h, required 0 %h %h %h",
                 i, ex_first, op_a, op_b, op_c, ha, hb, hc);
      end
    end
    wait_done(lat);
    ex_wait = 0;
    checks++;
    if (lat !== 13 || sb.size() != 0) begin
      errors++; $display("FAIL stall_latency: got %0d (%0d pending), required 13", lat, sb.size());
    end
  endtask

  task automatic test_scalar();
    int lat, seen;
    seen = 0;
    issue(8, 3'b001, 0, 14, 15, 16, 1'b1, 32'h0000_1234, -1);
    for (int i = 0; i < 60; i++) begin
      if (done_cnt != done_start) break;
      if (ex_first) begin
        seen++;
        checks++;
        if (op_a !== 32'h1234_1234) begin
          errors++; $display("FAIL scalar_operand: got %h, required 12341234", op_a);
        end
      end
      @(negedge clk);
    end
    wait_done(lat);
    checks++;
    if (seen !== 4 || lat !== 13) begin
      errors++; $display("FAIL scalar_words: got %0d words lat %0d, required 4 words lat 13", seen, lat);
    end
  endtask

  task automatic test_flush();
    int w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    issue(4, 3'b010, 17, 18, 19, 20, 1'b0, 32'h0, 1);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b, required 1", instr_ready); end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1 || done_cnt != d0 || sb.size() != 0) begin
      errors++; $display("FAIL flush_effect: got %0d writes %0d dones, required 1 write 0 dones", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_illegal();
    int lat, w0, r0;
    w0 = wr_cnt;
    r0 = re_cnt;
    issue(4, 3'b011, 1, 2, 3, 4, 1'b0, 32'h0, -1);
    wait_done(lat);
    checks++;
    if (lat !== 1 || err_at_done !== 1'b1) begin
      errors++; $display("FAIL illegal_done: got lat=%0d err=%b, required lat=1 err=1", lat, err_at_done);
    end
    checks++;
    if (wr_cnt != w0 || re_cnt != r0) begin
      errors++; $display("FAIL illegal_vrf: got writes=%0d reads=%0d, required 0 0", wr_cnt - w0, re_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, w0;
    w0 = wr_cnt;
    issue(3, 3'b001, 21, 22, 23, 21, 1'b0, 32'h0, -1);
    wait_done(lat1);
    issue(7, 3'b000, 24, 25, 26, 27, 1'b1, 32'hABCD_EF5A, -1);
    wait_done(lat2);
    checks++;
    if (lat1 !== 7 || lat2 !== 7 || wr_cnt - w0 !== 4 || sb.size() != 0) begin
      errors++; $display("FAIL back_to_back: got lat %0d/%0d writes %0d, required 7/7 writes 4", lat1, lat2, wr_cnt - w0);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    d0 = done_cnt;
    issue(4, 3'b010, 28, 29, 30, 31, 1'b0, 32'h0, 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_ready, vrf_we, vrf_re, done} !== 4'b1000 || op_a !== 32'h0) begin
      errors++; $display("FAIL async_reset: got rdy/we/re/done=%b a=%h, required 1000 a=0",
                         {instr_ready, vrf_we, vrf_re, done}, op_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt != d0 || sb.size() != 0) begin
      errors++; $display("FAIL async_reset_after: got %0d dones %0d pending, required 0 0", done_cnt - d0, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0; vl = '0; vsew = 3'b010;
    vs1 = '0; vs2 = '0; vs3 = '0; vd = '0;
    scalar_sel = 1'b0; scalar = '0; flush = 1'b0;
    for (int i = 0; i < 32 * WPR; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_sew32_full();
    test_sew8_tail();
    test_vl_zero();
    test_ex_stall();
    test_scalar();
    test_flush();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
